// File: rtl/ss_scan_pkg.sv
// Shared types and helpers for the time-multiplexed input stabilizer.
package ss_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Channel pointer width; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ss_scan_sync.sv
// N-bit two-flop synchronizer for asynchronous raw lines.
module ss_scan_sync #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] meta;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta <= '0;
            o_q  <= '0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/ss_scan.sv
// Round-robin input stabilizer: one shared settle counter serves N lines.
// Define SS_SCAN_SYNC_EN to pass i_in through a two-flop synchronizer.
module ss_scan
    import ss_scan_pkg::*;
#(
    parameter int N  = 4,
    parameter int D  = 3,
    parameter int CW = $clog2(D+1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N-1:0]         i_in,
    input  logic                 i_scan_en,
    output logic [N-1:0]         o_out,
    output logic                 o_chg_valid,
    output logic [$clog2(N)-1:0] o_chg_chan,
    output logic                 o_chg_val,
    input  logic                 i_chg_ready
);

    localparam int PW = ptr_w(N);

    logic [N-1:0] in_s;

`ifdef SS_SCAN_SYNC_EN
    ss_scan_sync #(.N(N)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_in),
        .o_q     (in_s)
    );
`else
    assign in_s = i_in;
`endif

    state_t               state, state_n;
    logic [PW-1:0]        p;
    logic [N-1:0][CW-1:0] cnt;

    logic          smp, differ, hit, visit, ack;
    logic [CW:0]   inc;

    // Single shared incrementer/comparator for the channel under visit.
    assign smp    = in_s[p];
    assign differ = smp ^ o_out[p];
    assign inc    = {1'b0, cnt[p]} + (CW+1)'(1);
    assign hit    = (inc == (CW+1)'(D));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        visit   = 1'b0;
        ack     = 1'b0;
        case (state)
            IDLE: if (i_scan_en) state_n = SCAN;
            SCAN: begin
                // Enable is checked before the visit: dropping it skips the slot.
                if (!i_scan_en) state_n = IDLE;
                else begin
                    visit = 1'b1;
                    if (differ && hit) state_n = HOLD;
                end
            end
            HOLD: begin
                if (o_chg_valid && i_chg_ready) begin
                    ack     = 1'b1;
                    state_n = i_scan_en ? SCAN : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_out       <= '0;
            o_chg_valid <= 1'b0;
            o_chg_chan  <= '0;
            o_chg_val   <= 1'b0;
            p           <= '0;
            cnt         <= '0;
        end else begin
            if (ack) o_chg_valid <= 1'b0;
            if (visit) begin
                p <= (p == PW'(N-1)) ? '0 : p + PW'(1);
                if (!differ) begin
                    cnt[p] <= '0;
                end else if (!hit) begin
                    cnt[p] <= inc[CW-1:0];
                end else begin
                    o_out[p]    <= smp;
                    cnt[p]      <= '0;
                    o_chg_valid <= 1'b1;
                    o_chg_chan  <= p;
                    o_chg_val   <= smp;
                end
            end
        end
    end

endmodule

// File: doc/ss_scan.md
# ss_scan

Time-multiplexed input stabilizer controller: one shared settle-counter datapath serves N slow control-unit input lines, with channels visited in round-robin order. A channel's output changes only after D consecutive visits sample the same new level. Each accepted change is reported to the sequencing logic over a one-entry valid/ready event port. The block sits between raw device/panel lines and the control-unit state machines, and replaces per-line settle instances.

## Interface

- `N`, default 4: number of input channels, N >= 2.
- `D`, default 3: consecutive differing visits needed to accept a change, D >= 1.
- `CW`, default $clog2(D+1): per-channel counter width.
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_in`  in  N  raw input lines.
- `i_scan_en`  in  1  enables scanning.
- `o_out`  out  N  stabilized levels.
- `o_chg_valid`  out  1  change event pending.
- `o_chg_chan`  out  $clog2(N)  channel of pending event.
- `o_chg_val`  out  1  new level of pending event.
- `i_chg_ready`  in  1  consumer accepts event.

## Operation

- States: IDLE, SCAN, HOLD. Reset state is IDLE.
- Reset values: o_out = 0, o_chg_valid = 0, o_chg_chan = 0, o_chg_val = 0, pointer p = 0, all counters = 0.
- IDLE -> SCAN when i_scan_en = 1. No sampling occurs in the cycle of that transition.
- SCAN, each cycle, visits channel p with sample s:
  - s == o_out[p]: cnt[p] <= 0.
  - s != o_out[p] and cnt[p]+1 < D: cnt[p] <= cnt[p]+1.
  - s != o_out[p] and cnt[p]+1 == D: o_out[p] <= s, cnt[p] <= 0, o_chg_valid <= 1, o_chg_chan <= p, o_chg_val <= s, next state HOLD.
  - p <= (p == N-1) ? 0 : p+1 on every SCAN cycle, including the event cycle.
- SCAN -> IDLE when i_scan_en = 0, evaluated before the visit, so no visit happens that cycle. p and counters are retained.
- HOLD: no visits, no pointer movement, counters frozen. On o_chg_valid & i_chg_ready: o_chg_valid <= 0; next state is SCAN if i_scan_en = 1, else IDLE.
- o_chg_chan and o_chg_val are stable while o_chg_valid = 1. Only one event is ever outstanding, so no event is dropped.
- Counter arithmetic: cnt saturates at D-1 by construction; there is no wrap. With D = 1, any single differing visit is accepted.
- Asynchronous reset mid-count or mid-HOLD: immediate return to reset values. A pending event is discarded.

## Timing

- Unstalled SCAN: each channel is visited exactly every N cycles.
- o_out[p] and o_chg_valid update on the same edge: the D-th consecutive differing visit.
- Without sync: a change stable from visit k onward is accepted N*(D-1) cycles after visit k. With sync: add 2 cycles of input delay.
- Each HOLD cycle adds one cycle to the revisit interval of every channel.
- Handshake: an event is transferred in the cycle with valid & ready both high. Minimum 1 HOLD cycle per event when ready is held high.
- i_chg_ready is ignored while o_chg_valid = 0.

## Configuration

- `SS_SCAN_SYNC_EN` defined: each i_in bit passes through a two-flop synchronizer, reset to 0, before sampling. Use for truly asynchronous lines.
- `SS_SCAN_SYNC_EN` undefined: i_in is sampled directly, and the inputs must be synchronous to i_clk. Latency is 2 cycles lower.

## Structure

- Package `ss_scan_pkg`: state enum (IDLE, SCAN, HOLD) and the pointer-width helper function.
- Sub-module `ss_scan_sync`: N-bit two-flop synchronizer with asynchronous active-low reset. Instantiated only under SS_SCAN_SYNC_EN.
- Counters are held in an N x CW register array inside ss_scan with a single shared incrementer/comparator.

## Test plan

All scenarios use N=4, D=3, sync off, unless stated otherwise.

- Reset with i_in = 4'b1111 asserted -> o_out = 0, o_chg_valid = 0. After release and i_scan_en = 1: the first visit to ch0 is on the second clock edge.
- i_in[2] = 1 held, i_chg_ready = 1 -> o_out[2] rises on the 3rd ch2 visit (8 cycles after the 1st) with o_chg_valid high, o_chg_chan = 2, o_chg_val = 1 for one cycle. o_out[0,1,3] = 0.
- i_in[1] = 1 for exactly 2 ch1 visits, then 0 -> no change on o_out[1], no event. A following 3-visit pulse is accepted.
- i_chg_ready = 0 while ch0 and ch1 both change -> the ch0 event is held and p stays at 1. o_out[1] is unchanged until ready = 1, then the ch1 event follows.
- Async reset asserted mid-count (cnt[3] = 2) and mid-HOLD -> all outputs 0 immediately. After release, ch3 needs 3 fresh visits.
- D=1 instance with SS_SCAN_SYNC_EN -> a single visit accepts the change, 2 cycles after the first sample at the input.
